layer_train_scheduler: RTL and testbench

- Sequences forward and learning passes over a chain of LAYERS neuron_learn_layerNN instances that share one clock.
- Accepts one training/inference sample per valid/ready handshake and strobes each layer's valid input in order, front to back.
- Presents the network result via a valid/ready handshake.
- In training mode, then strobes each layer's learn input in reverse order, back to front, so expected_in propagates backwards.
- Counts samples and epochs; raises done when the programmed epoch target is reached.

---
 rtl/layer_train_scheduler_pkg.sv | 16 +
 rtl/layer_train_scheduler_timer.sv | 28 ++
 rtl/layer_train_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_layer_train_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_train_scheduler_pkg.sv
// Shared types and defaults for the layer training scheduler.
package layer_train_scheduler_pkg;

    localparam int unsigned SCHED_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FWD_STROBE = 3'd1,
        FWD_WAIT   = 3'd2,
        RESULT     = 3'd3,
        LRN_STROBE = 3'd4,
        LRN_WAIT   = 3'd5,
        COMMIT     = 3'd6
    } sched_state_t;

endpackage

// File: rtl/layer_train_scheduler_timer.sv
// Loadable down-counter used for the forward and learn settle waits.
module layer_step_timer
    import layer_train_scheduler_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/layer_train_scheduler.sv
// Sequences forward (front to back) and learn (back to front) strobes over a layer chain.
// Optional stall_cycles counter enabled by defining LAYER_TRAIN_SCHED_STALL_CNT_EN.
module layer_train_scheduler
    import layer_train_scheduler_pkg::*;
#(
    parameter int unsigned LAYERS  = 3,
    parameter int unsigned FWD_LAT = 2,
    parameter int unsigned LRN_LAT = 2,
    parameter int unsigned CNT_W   = SCHED_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              train_mode,
    input  logic [CNT_W-1:0]  epochs_target,
    input  logic              sample_valid,
    input  logic              sample_last,
    output logic              sample_ready,
    output logic [LAYERS-1:0] layer_valid,
    output logic [LAYERS-1:0] layer_learn,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  epoch_count,
`ifdef LAYER_TRAIN_SCHED_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cycles,
`endif
    output logic              done
);

    localparam int unsigned IDX_W    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int unsigned MAX_LAT  = (FWD_LAT > LRN_LAT) ? FWD_LAT : LRN_LAT;
    localparam int unsigned TMR_W    = $clog2(MAX_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYERS - 1);

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              train_q, train_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic              done_q, done_d;

    logic              ready_q, ready_d;
    logic [LAYERS-1:0] lvalid_q, lvalid_d;
    logic [LAYERS-1:0] llearn_q, llearn_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;

    logic              accept_c;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

`ifdef LAYER_TRAIN_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_q, stall_d;
`endif

    layer_step_timer #(.W(TMR_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign accept_c = (state_q == IDLE) && sample_valid && ready_q;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        train_d  = train_q;
        last_d   = last_q;
        target_d = target_q;
        scnt_d   = scnt_q;
        ecnt_d   = ecnt_q;
        done_d   = done_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    train_d  = train_mode;
                    last_d   = sample_last;
                    target_d = epochs_target;
                    idx_d    = '0;
                    state_d  = FWD_STROBE;
                end
            end
            FWD_STROBE: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(FWD_LAT - 1);
                state_d  = FWD_WAIT;
            end
            FWD_WAIT: begin
                if (tmr_zero) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = RESULT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FWD_STROBE;
                    end
                end
            end
            RESULT: begin
                if (result_ready) begin
                    if (train_q) begin
                        idx_d   = LAST_IDX;
                        state_d = LRN_STROBE;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            LRN_STROBE: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(LRN_LAT - 1);
                state_d  = LRN_WAIT;
            end
            LRN_WAIT: begin
                if (tmr_zero) begin
                    if (idx_q == '0) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = LRN_STROBE;
                    end
                end
            end
            COMMIT: begin
                if (last_q) begin
                    scnt_d = '0;
                    if (ecnt_q != '1) begin
                        ecnt_d = ecnt_q + CNT_W'(1);
                    end
                    if ((target_q != '0) && (ecnt_d == target_q)) begin
                        done_d = 1'b1;
                    end
                end else if (scnt_q != '1) begin
                    scnt_d = scnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        ready_d  = (state_d == IDLE) && !done_d;
        lvalid_d = (state_d == FWD_STROBE) ? (LAYERS'(1) << idx_d) : '0;
        llearn_d = (state_d == LRN_STROBE) ? (LAYERS'(1) << idx_d) : '0;
        rvalid_d = (state_d == RESULT);
        busy_d   = (state_d != IDLE);
    end

`ifdef LAYER_TRAIN_SCHED_STALL_CNT_EN
    // Cycles the result sat unconsumed, cleared by each new sample.
    always_comb begin
        stall_d = stall_q;
        if (accept_c) begin
            stall_d = '0;
        end else if ((state_q == RESULT) && !result_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            train_q  <= 1'b0;
            last_q   <= 1'b0;
            target_q <= '0;
            scnt_q   <= '0;
            ecnt_q   <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            lvalid_q <= '0;
            llearn_q <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            train_q  <= train_d;
            last_q   <= last_d;
            target_q <= target_d;
            scnt_q   <= scnt_d;
            ecnt_q   <= ecnt_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            lvalid_q <= lvalid_d;
            llearn_q <= llearn_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
        end
    end

    assign sample_ready = ready_q;
    assign layer_valid  = lvalid_q;
    assign layer_learn  = llearn_q;
    assign result_valid = rvalid_q;
    assign busy         = busy_q;
    assign sample_count = scnt_q;
    assign epoch_count  = ecnt_q;
    assign done         = done_q;

endmodule

// File: tb/tb_layer_train_scheduler.sv
// Self-checking bench for layer_train_scheduler; set LAYER_TRAIN_SCHED_STALL_CNT_EN to cover stall_cycles.
module tb_layer_train_scheduler;

    localparam int unsigned LAYERS  = 3;
    localparam int unsigned FWD_LAT = 2;
    localparam int unsigned LRN_LAT = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int FP = LAYERS * (1 + FWD_LAT);
    localparam int LP = LAYERS * (1 + LRN_LAT);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              train_mode = 1'b0;
    logic [CNT_W-1:0]  epochs_target = '0;
    logic              sample_valid = 1'b0;
    logic              sample_last = 1'b0;
    logic              sample_ready;
    logic [LAYERS-1:0] layer_valid;
    logic [LAYERS-1:0] layer_learn;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  sample_count;
    logic [CNT_W-1:0]  epoch_count;
    logic              done;
`ifdef LAYER_TRAIN_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cycles;
`endif

    layer_train_scheduler #(
        .LAYERS (LAYERS),
        .FWD_LAT(FWD_LAT),
        .LRN_LAT(LRN_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .train_mode   (train_mode),
        .epochs_target(epochs_target),
        .sample_valid (sample_valid),
        .sample_last  (sample_last),
        .sample_ready (sample_ready),
        .layer_valid  (layer_valid),
        .layer_learn  (layer_learn),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .sample_count (sample_count),
        .epoch_count  (epoch_count),
`ifdef LAYER_TRAIN_SCHED_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             train;
        logic             last;
        int               rdy;
        logic [CNT_W-1:0] exp_sc;
        logic [CNT_W-1:0] exp_ec;
        logic             exp_done;
    } vec_t;

    vec_t tbl[6];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int exp_next_acc = -1;

    // Reference model state: counts as seen once a sample has committed.
    logic [CNT_W-1:0] sc_m = '0;
    logic [CNT_W-1:0] ec_m = '0;
    logic [CNT_W-1:0] tgt_m = '0;
    logic             done_m = 1'b0;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic logic [LAYERS-1:0] bit_of(input int k);
        bit_of = LAYERS'(1) << k;
    endfunction

    function automatic logic [63:0] all_outs();
        all_outs = 64'({sample_ready, layer_valid, layer_learn, result_valid, busy,
                        sample_count, epoch_count, done});
    endfunction

    function automatic void model_commit(input logic last);
        if (last) begin
            sc_m = '0;
            if (ec_m != '1) ec_m = ec_m + CNT_W'(1);
            if (tgt_m != '0 && ec_m == tgt_m) done_m = 1'b1;
        end else if (sc_m != '1) begin
            sc_m = sc_m + CNT_W'(1);
        end
    endfunction

    // Offer one sample, check every cycle's strobes against the timeline, then the committed counts.
    task automatic run_sample(input logic train, input logic last, input int rdy);
        int acc, h, endo, off, q, w;
        logic [LAYERS-1:0] elv, ell;
        logic erv;
        train_mode    = train;
        sample_last   = last;
        epochs_target = tgt_m;
        sample_valid  = 1'b1;
        result_ready  = 1'b0;
        w = 0;
        while (sample_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w == 100) begin
            chk("accept_timeout", 64'(0), 64'(1));
            sample_valid = 1'b0;
            exp_next_acc = -1;
            return;
        end
        acc = cyc;
        if (exp_next_acc >= 0) chk("sample_period", 64'(acc), 64'(exp_next_acc));
        h    = acc + FP + 1 + rdy;
        endo = h + (train ? LP : 0) + 1;
        tick();
        sample_valid  = 1'b0;
        train_mode    = ~train;
        sample_last   = ~last;
        epochs_target = CNT_W'($urandom);
        while (cyc <= endo) begin
            off = cyc - acc;
            elv = '0;
            ell = '0;
            erv = 1'b0;
            if (off <= FP) begin
                if ((off - 1) % (1 + FWD_LAT) == 0) elv = bit_of((off - 1) / (1 + FWD_LAT));
            end else if (cyc <= h) begin
                erv = 1'b1;
            end else if (train && cyc < endo) begin
                q = cyc - h;
                if ((q - 1) % (1 + LRN_LAT) == 0) ell = bit_of(LAYERS - 1 - (q - 1) / (1 + LRN_LAT));
            end
            chk("strobes", 64'({busy, result_valid, layer_learn, layer_valid}),
                64'({1'b1, erv, ell, elv}));
            result_ready = (cyc >= h);
            tick();
        end
        model_commit(last);
        chk("sample_count", 64'(sample_count), 64'(sc_m));
        chk("epoch_count", 64'(epoch_count), 64'(ec_m));
        chk("done", 64'(done), 64'(done_m));
        chk("idle_ready_busy", 64'({sample_ready, busy}), 64'({~done_m, 1'b0}));
`ifdef LAYER_TRAIN_SCHED_STALL_CNT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(rdy));
`endif
        exp_next_acc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, bad;
        tbl[0] = '{1'b0, 1'b0, 0, 16'd1, 16'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1, 16'd2, 16'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 0, 16'd0, 16'd1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 2, 16'd1, 16'd1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 0, 16'd2, 16'd1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 0, 16'd0, 16'd2, 1'b1};

        // Reset state
        tick();
        tick();
        chk("reset_outputs", all_outs(), 64'(0));
        reset = 1'b0;
        tick();
        chk("post_reset_ready", all_outs(), 64'({1'b1, 41'(0)}));

        // Forward only, then train, then a stalled result, all back to back
        run_sample(1'b0, 1'b0, 0);
        run_sample(1'b1, 1'b0, 0);
        run_sample(1'b0, 1'b0, 5);
        run_sample(1'b1, 1'b0, 0);
        run_sample(1'b1, 1'b0, 0);

        // Randomized samples, unlimited epochs
        for (int n = 0; n < 30; n++) begin
            run_sample(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                       int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while waiting between learn strobes
        train_mode    = 1'b1;
        sample_last   = 1'b0;
        epochs_target = '0;
        result_ready  = 1'b1;
        sample_valid  = 1'b1;
        w = 0;
        while (sample_ready !== 1'b1 && w < 100) begin tick(); w++; end
        tick();
        sample_valid = 1'b0;
        w = 0;
        while (layer_learn == '0 && w < 100) begin tick(); w++; end
        chk("learn_seen_before_reset", 64'(layer_learn != '0), 64'(1));
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_clear", all_outs(), 64'(0));
        tick();
        #2;
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 64'({sample_ready, busy, layer_valid, layer_learn}),
            64'({1'b1, 1'b0, LAYERS'(0), LAYERS'(0)}));
        sc_m = '0;
        ec_m = '0;
        done_m = 1'b0;
        exp_next_acc = -1;

        // Two epochs of three samples, then done
        tgt_m = CNT_W'(2);
        for (int i = 0; i < 6; i++) begin
            run_sample(tbl[i].train, tbl[i].last, tbl[i].rdy);
            chk("tbl_counts", 64'({sample_count, epoch_count, done}),
                64'({tbl[i].exp_sc, tbl[i].exp_ec, tbl[i].exp_done}));
        end

        // A further sample is refused while done
        sample_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sample_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        sample_valid = 1'b0;
        chk("done_blocks_accept", 64'(bad), 64'(0));
        chk("done_counts_hold", 64'({sample_count, epoch_count, done}),
            64'({CNT_W'(0), CNT_W'(2), 1'b1}));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
